// File: rtl/rr_arbiter.sv
// Round-robin arbiter: registered one-hot grant plus its binary index,
// with a bounded hold time so a persistent requester cannot starve others.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 4,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [IDX_W:0]   N_W      = (IDX_W + 1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [N-1:0]     ONE_HOT0 = N'(1);

    logic [0:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [HOLD_W-1:0] hold;

    logic              found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W:0]    cand;
    logic              others_req;
    logic [IDX_W-1:0]  next_ptr;

    // Circular search from ptr; the explicit wrap keeps indices below N.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found    = 1'b1;
                pick_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign others_req = |(req & ~grant);
    assign next_ptr   = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            hold        <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && found) begin
                        grant       <= ONE_HOT0 << pick_idx;
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        hold        <= HOLD_W'(1);
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Release and preempt both end in a single turnaround idle cycle.
                    if (!en || !req[grant_idx] || (hold == HOLD_MAX && others_req)) begin
                        grant       <= '0;
                        grant_idx   <= '0;
                        grant_valid <= 1'b0;
                        hold        <= '0;
                        ptr         <= next_ptr;
                        state       <= IDLE;
                    end else if (hold != HOLD_MAX) begin
                        hold <= hold + HOLD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: a 4-requester instance for most scenarios
// and a 3-requester instance for the non-power-of-2 wrap.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic [2:0] req3;
    logic [2:0] grant3;
    logic [1:0] idx3;
    logic       valid3;

    int vectors;
    int miscompares;

    rr_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
    );

    rr_arbiter #(.N(3), .MAX_HOLD(4)) dut3 (
        .clk(clk), .rst(rst), .en(en), .req(req3),
        .grant(grant3), .grant_idx(idx3), .grant_valid(valid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic reset_dut();
        rst = 1'b1; en = 1'b1; req = 4'b0000; req3 = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 4'b0000; req3 = 3'b000;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({grant, grant_idx, grant_valid} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_state got %b/%0d/%b want 0000/0/0", grant, grant_idx, grant_valid);
        end
        rst = 1'b0; req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({grant, grant_idx, grant_valid} !== {4'b0001, 2'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_grant got %b/%0d/%b want 0001/0/1", grant, grant_idx, grant_valid);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({grant, grant_idx, grant_valid} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got %b/%0d/%b want 0000/0/0", grant, grant_idx, grant_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({grant, grant_idx, grant_valid} !== {4'b0001, 2'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL first_grant got %b/%0d/%b want 0001/0/1", grant, grant_idx, grant_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset_dut();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                vectors++;
                if ({grant, grant_idx, grant_valid} !== {exp_seq[k], onehot_idx(exp_seq[k]), 1'b1}) begin
                    miscompares++;
                    $display("[TB] FAIL rr_grant%0d_c%0d got %b/%0d want %b/%0d", k, c, grant, grant_idx, exp_seq[k], onehot_idx(exp_seq[k]));
                end
            end
            req = 4'b1111 & ~exp_seq[k];
            @(negedge clk);
            vectors++;
            if ({grant, grant_valid} !== 5'b0) begin
                miscompares++;
                $display("[TB] FAIL rr_idle%0d got %b/%b want 0000/0", k, grant, grant_valid);
            end
            req = 4'b1111;
        end
        req = 4'b0000;
    endtask

    task automatic test_preempt();
        logic [3:0] exp_seq [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                    4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
        reset_dut();
        req = 4'b0011;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            vectors++;
            if ({grant, grant_idx, grant_valid} !== {exp_seq[k], onehot_idx(exp_seq[k]), |exp_seq[k]}) begin
                miscompares++;
                $display("[TB] FAIL preempt_cyc%0d got %b/%0d/%b want %b/%0d/%b", k, grant, grant_idx, grant_valid, exp_seq[k], onehot_idx(exp_seq[k]), |exp_seq[k]);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_no_competition();
        reset_dut();
        req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vectors++;
            if ({grant, grant_idx, grant_valid} !== {4'b0100, 2'd2, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL solo_cyc%0d got %b/%0d/%b want 0100/2/1", k, grant, grant_idx, grant_valid);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_enable();
        reset_dut();
        en = 1'b0; req = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if ({grant, grant_valid} !== 5'b0) begin
                miscompares++;
                $display("[TB] FAIL en_low_cyc%0d got %b/%b want 0000/0", k, grant, grant_valid);
            end
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if ({grant, grant_idx, grant_valid} !== {4'b1000, 2'd3, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL en_grant got %b/%0d/%b want 1000/3/1", grant, grant_idx, grant_valid);
        end
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({grant, grant_valid} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL en_drop got %b/%b want 0000/0", grant, grant_valid);
        end
        en = 1'b1; req = 4'b1111;
        @(negedge clk);
        vectors++;
        if ({grant, grant_idx, grant_valid} !== {4'b0001, 2'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL en_wrap_ptr got %b/%0d/%b want 0001/0/1", grant, grant_idx, grant_valid);
        end
        req = 4'b0000;
    endtask

    task automatic test_non_pow2();
        logic [1:0] exp_idx [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [2:0] exp_oh;
        reset_dut();
        req3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            exp_oh = 3'b001 << exp_idx[k];
            @(negedge clk);
            vectors++;
            if ({grant3, idx3, valid3} !== {exp_oh, exp_idx[k], 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL n3_grant%0d got %b/%0d/%b want %b/%0d/1", k, grant3, idx3, valid3, exp_oh, exp_idx[k]);
            end
            req3 = 3'b111 & ~exp_oh;
            @(negedge clk);
            vectors++;
            if ({grant3, valid3} !== 4'b0) begin
                miscompares++;
                $display("[TB] FAIL n3_idle%0d got %b/%b want 000/0", k, grant3, valid3);
            end
            req3 = 3'b111;
        end
        req3 = 3'b000;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_round_robin();
        test_preempt();
        test_no_competition();
        test_enable();
        test_non_pow2();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
